// File: rtl/mdu_iter_if.sv
// Decoder-to-MDU bus: command and operands in; HI/LO, mul_out, stall and FSM state out.
// Strict timing contract: the core holds mdu/a/b while stall is high; the instruction retires in the first cycle stall is low.
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic [2:0]      mdu;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] mul_out;
    logic            stall;
    logic            busy;
    logic [1:0]      dbg_state;

    modport master (
        output mdu, a, b,
        input  hi, lo, mul_out, stall, busy, dbg_state
    );

    modport slave (
        input  mdu, a, b,
        output hi, lo, mul_out, stall, busy, dbg_state
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO; stalls the core while MULT/MULTU/DIV/DIVU run.
// Optional macro MDU_FAST_MUL_EN: MULT/MULTU finish in the issue cycle, divides stay iterative.
module mdu_iter #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic      clk,
    input  logic      rst_n,
    mdu_iter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_is_div, r_neg_q, r_neg_r;
    logic [XLEN-1:0]   r_opb, r_rem, r_hi, r_lo;
    logic [2*XLEN-1:0] r_acc;

    logic              w_stall, w_busy;
    logic              w_is_signed, w_is_div, w_div0, w_start;
    logic [XLEN-1:0]   w_opa, w_opb;
    logic [XLEN:0]     w_msum, w_trial;
    logic [2*XLEN-1:0] w_mul_nxt, w_prod;
    logic [XLEN-1:0]   w_sub, w_rem_nxt, w_quo_nxt, w_quo_fix, w_rem_fix;
    logic              w_qbit;

    assign w_is_signed = (bus.mdu == OP_MULT) || (bus.mdu == OP_DIV);
    assign w_is_div    = (bus.mdu == OP_DIV) || (bus.mdu == OP_DIVU);
    assign w_div0      = w_is_div && (bus.b == '0);

`ifdef MDU_FAST_MUL_EN
    logic                     w_fast;
    logic signed [2*XLEN-1:0] w_sprod;
    logic [2*XLEN-1:0]        w_uprod, w_fast_prod;
    assign w_fast      = (bus.mdu == OP_MULT) || (bus.mdu == OP_MULTU);
    assign w_start     = w_is_div;
    assign w_sprod     = $signed(bus.a) * $signed(bus.b);
    assign w_uprod     = {{XLEN{1'b0}}, bus.a} * {{XLEN{1'b0}}, bus.b};
    assign w_fast_prod = (bus.mdu == OP_MULT) ? w_sprod : w_uprod;
`else
    assign w_start = (bus.mdu >= OP_MULT) && (bus.mdu <= OP_DIVU);
`endif

    // A zero divisor keeps the raw dividend unsigned so the datapath leaves hi=a, lo=all-ones.
    assign w_opa = (w_is_signed && bus.a[XLEN-1] && !w_div0) ? -bus.a : bus.a;
    assign w_opb = (w_is_signed && bus.b[XLEN-1]) ? -bus.b : bus.b;

    // Shift-add multiply: upper half accumulates, multiplier shifts out of the lower half.
    assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};
    assign w_prod    = r_neg_q ? -w_mul_nxt : w_mul_nxt;

    // Restoring divide: dividend shifts out of r_acc[XLEN-1:0] as quotient bits shift in.
    assign w_trial   = {r_rem, r_acc[XLEN-1]};
    assign w_qbit    = (w_trial >= {1'b0, r_opb});
    assign w_sub     = w_trial[XLEN-1:0] - r_opb;
    assign w_rem_nxt = w_qbit ? w_sub : w_trial[XLEN-1:0];
    assign w_quo_nxt = {r_acc[XLEN-2:0], w_qbit};
    assign w_quo_fix = r_neg_q ? -w_quo_nxt : w_quo_nxt;
    assign w_rem_fix = r_neg_r ? -w_rem_nxt : w_rem_nxt;

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_stall = 1'b1;
                w_busy  = 1'b1;
                if (r_cnt == '1) w_state_nxt = S_DONE;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_opb    <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_is_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]) && !w_div0;
                        r_neg_r  <= w_is_signed && bus.a[XLEN-1] && !w_div0;
                        r_opb    <= w_opb;
                        r_rem    <= '0;
                        r_acc    <= {{XLEN{1'b0}}, w_opa};
                        r_cnt    <= '0;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (w_fast) begin
                        r_hi <= w_fast_prod[2*XLEN-1:XLEN];
                        r_lo <= w_fast_prod[XLEN-1:0];
                    end
`endif
                    else if (bus.mdu == OP_MTHI) begin
                        r_hi <= bus.a;
                    end else if (bus.mdu == OP_MTLO) begin
                        r_lo <= bus.a;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_is_div) begin
                        r_rem <= w_rem_nxt;
                        r_acc <= {r_acc[2*XLEN-1:XLEN], w_quo_nxt};
                    end else begin
                        r_acc <= w_mul_nxt;
                    end
                    if (r_cnt == '1) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod[2*XLEN-1:XLEN];
                            r_lo <= w_prod[XLEN-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // stall is forced low while reset is asserted even if a command is on the bus.
    assign bus.stall     = w_stall & rst_n;
    assign bus.busy      = w_busy;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.mul_out   = bus.a * bus.b;
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus random commands against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_mdu_iter;
`ifdef MDU_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int STALL_LEN = 33;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_iter_if bus ();
    mdu_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from 64-bit integer arithmetic.
    function automatic logic [63:0] ref_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (cmd)
            3'd1: begin q = sa * sb; return q; end
            3'd2: begin p = ua * ub; return p; end
            3'd3, 3'd4: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (cmd == 3'd3) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = longint'(ua / ub);
                    r = longint'(ua % ub);
                end
                return {r[31:0], q[31:0]};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: a falling stall marks a completed op; pop and compare HI/LO and stall length.
    int stall_run = 0;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_run  = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.stall) begin
                check("busy_during_stall", 64'(bus.busy), 64'(stall_run != 0));
                stall_run++;
            end else if (prev_stall) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("hilo", {bus.hi, bus.lo}, exp_q.pop_front());
                    check("stall_len", 64'(stall_run), 64'(STALL_LEN));
                end
                check("busy_done", 64'(bus.busy), 64'd0);
                stall_run = 0;
            end
            prev_stall = bus.stall;
        end
    end

    // Starts and ends one cycle after a rising edge; holds the command until it retires.
    task automatic exec(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r, pm;
        bit stalls;
        int k;
        bus.mdu = cmd;
        bus.a   = a;
        bus.b   = b;
        r  = ref_op(cmd, a, b);
        pm = ref_op(3'd1, a, b);
        stalls = (cmd == 3'd3) || (cmd == 3'd4) || (!FAST && (cmd == 3'd1 || cmd == 3'd2));
        #1;
        check("mul_out", 64'(bus.mul_out), 64'(pm[31:0]));
        if (stalls) begin
            exp_q.push_back(r);
            check("stall_issue", 64'(bus.stall), 64'd1);
            k = 0;
            do begin
                @(posedge clk);
                #1;
                k++;
            end while (bus.stall && k < 60);
            if (bus.stall) check("stall_timeout", 64'(bus.stall), 64'd0);
            {m_hi, m_lo} = r;
            @(posedge clk);
            #1;
        end else begin
            check("stall_none", 64'(bus.stall), 64'd0);
            @(posedge clk);
            #1;
            if (cmd == 3'd5) m_hi = a;
            if (cmd == 3'd6) m_lo = a;
            if (cmd == 3'd1 || cmd == 3'd2) {m_hi, m_lo} = r;
            check("hi_direct", 64'(bus.hi), 64'(m_hi));
            check("lo_direct", 64'(bus.lo), 64'(m_lo));
        end
    endtask

    task automatic idle_check();
        bus.mdu = 3'd0;
        #1;
        check("idle_stall", 64'(bus.stall), 64'd0);
        check("idle_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        check("idle_state", 64'(bus.dbg_state), 64'd0);
    endtask

    initial begin
        bus.mdu = 3'd1;
        bus.a   = 32'h5;
        bus.b   = 32'h7;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        bus.mdu = 3'd0;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        exec(3'd1, 32'hFFFF_FFFE, 32'd3);
        exec(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exec(3'd3, 32'hFFFF_FFF9, 32'd2);
        exec(3'd4, 32'd7, 32'd0);
        exec(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        exec(3'd3, 32'hFFFF_FFF9, 32'd0);
        exec(3'd5, 32'h1234_5678, 32'h0);
        exec(3'd6, 32'h9ABC_DEF0, 32'h0);

        // The DONE cycle keeps mdu=DIV on the bus; it must not re-issue.
        exec(3'd3, 32'd100, 32'd7);
        idle_check();
        exec(3'd3, 32'hFFFF_FF9C, 32'd7);
        exec(3'd4, 32'hDEAD_BEEF, 32'd16);

        // Reset in the middle of a DIVU at iteration 10 aborts it.
        bus.mdu = 3'd4;
        bus.a   = 32'hFFFF_0000;
        bus.b   = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        check("pre_reset_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        check("abort_stall", 64'(bus.stall), 64'd0);
        check("abort_busy", 64'(bus.busy), 64'd0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        bus.mdu = 3'd0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        exec(3'd2, 32'd3, 32'd5);

        for (int i = 0; i < 24; i++) begin
            exec(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end

        idle_check();
        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
